dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 8 lines x 4 bytes, direct-mapped, write-back, write-allocate.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 CLK  input  1  clock; all state changes on posedge.
REQ-004 RESET  input  1  synchronous active-low reset; 0 sampled at posedge resets the block.
REQ-005 READ  input  1  CPU load request, held until BUSYWAIT low.
REQ-006 WRITE  input  1  CPU store request, held until BUSYWAIT low.
REQ-007 ADDRESS  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
REQ-008 WRITEDATA  input  8  store data; driven by register-file OUT1.
REQ-009 READDATA  output  8  load data; consumed by register-file IN.
REQ-010 BUSYWAIT  output  1  stall to CPU and register-file BUSYWAIT.
REQ-011 MEM_READ  output  1  block fetch request to main memory.
REQ-012 MEM_WRITE  output  1  block writeback request to main memory.
REQ-013 MEM_ADDRESS  output  6  block address {tag,index}.
REQ-014 MEM_WRITEDATA  output  32  writeback block; byte 0 in [7:0].
REQ-015 MEM_READDATA  input  32  fetched block; byte 0 in [7:0].
REQ-016 MEM_BUSYWAIT  input  1  memory busy; request complete at first posedge sampling 0 while request asserted.

Function
REQ-017 Per line: 32-bit data, 3-bit tag, valid bit, dirty bit.
REQ-018 Hit = valid[index] and tag[index]==ADDRESS[7:5]; combinational from current inputs.
REQ-019 READ and WRITE both high SHALL be treated as WRITE.
REQ-020 FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
REQ-021 IDLE, no request: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0.
REQ-022 IDLE, read hit: READDATA = selected byte combinationally, BUSYWAIT=0, zero-cycle stall.
REQ-023 IDLE, write hit: BUSYWAIT=0; at next posedge byte[offset]<=WRITEDATA, dirty<=1.
REQ-024 IDLE, miss: BUSYWAIT=1 combinationally same cycle; next state WRITEBACK if line valid and dirty, else FETCH.
REQ-025 WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data, BUSYWAIT=1; on posedge with MEM_BUSYWAIT=0 go FETCH.
REQ-026 FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2], BUSYWAIT=1; on posedge with MEM_BUSYWAIT=0 latch MEM_READDATA internally, go UPDATE.
REQ-027 UPDATE: BUSYWAIT=1, no memory request; at posedge write line data, tag, valid<=1, dirty<=0; go IDLE.
REQ-028 After UPDATE the held request hits in IDLE; the write is applied via the REQ-023 hit path.
REQ-029 MEM_READ and MEM_WRITE SHALL never be high together; both are low outside WRITEBACK/FETCH.
REQ-030 READDATA outside a read hit SHALL hold the byte addressed by current ADDRESS (don't-care to CPU).
REQ-031 If READ/WRITE drop mid-miss, the current memory transaction SHALL still complete through UPDATE, then IDLE.
REQ-032 An outstanding memory request SHALL hold MEM_ADDRESS/MEM_WRITEDATA stable until completion.

Reset
REQ-033 On RESET=0 at posedge: state<=IDLE, all valid<=0, all dirty<=0, regardless of current state.
REQ-034 Reset mid-WRITEBACK/FETCH SHALL abandon the transfer; MEM_READ=MEM_WRITE=0 from the following cycle.
REQ-035 After reset, with no request: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0; data and tag arrays need not be cleared.

Verification
REQ-036 Cold read: reset, READ=1 ADDRESS=8'h25, memory returns 32'hDDCCBBAA after 3 busy cycles -> one FETCH with MEM_ADDRESS=6'h09, BUSYWAIT high through UPDATE, then READDATA=8'hBB.
REQ-037 Write hit: after REQ-036, WRITE=1 ADDRESS=8'h27 WRITEDATA=8'h5A -> BUSYWAIT=0, next READ 8'h27 returns 8'h5A, no memory access.
REQ-038 Dirty eviction: after REQ-037, READ ADDRESS=8'h45 -> WRITEBACK MEM_ADDRESS=6'h09 MEM_WRITEDATA=32'h5ACCBBAA, then FETCH MEM_ADDRESS=6'h11; no overlap of MEM_READ and MEM_WRITE.
REQ-039 Clean eviction: READ 8'h05 then READ 8'h85 (same index, clean) -> FETCH only, no MEM_WRITE.
REQ-040 Reset mid-FETCH: RESET=0 while MEM_READ=1 -> MEM_READ=0 next cycle, BUSYWAIT=0, previous line misses on re-read.
REQ-041 READ and WRITE both high on miss to 8'h10 -> behaves as write; line dirty, byte 0 = WRITEDATA afterwards.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU-side and memory-side signal bundle for dcache_ctrl
// Purpose: groups the CPU load/store port and the main-memory block port.
// Ports (signals):
//   CPU    : READ, WRITE, ADDRESS[7:0], WRITEDATA[7:0] -> cache ; READDATA[7:0], BUSYWAIT <- cache
//   Memory : MEM_READ, MEM_WRITE, MEM_ADDRESS[5:0], MEM_WRITEDATA[31:0] <- cache ;
//            MEM_READDATA[31:0], MEM_BUSYWAIT -> cache
// Modports: slave = the cache controller, master = the surrounding CPU/memory environment.
interface dcache_ctrl_if;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - 8-line x 4-byte direct-mapped write-back write-allocate data cache
// Purpose: services byte loads/stores from the CPU, fetching and writing back
//          whole 32-bit blocks from/to main memory on a miss.
// Ports:
//   CLK   - clock, all state changes on posedge
//   RESET - synchronous active-low reset
//   bus   - dcache_ctrl_if.slave (CPU request/response and memory block port)
module dcache_ctrl (
    input  logic         CLK,
    input  logic         RESET,
    dcache_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_data [0:7];
    logic [2:0]  r_tag  [0:7];
    logic [7:0]  r_valid;
    logic [7:0]  r_dirty;

    // Block address of the miss being serviced; keeps the memory request
    // stable even if the CPU changes or drops its request mid-miss.
    logic [5:0]  r_miss_blk;
    logic [31:0] r_fill;

    logic [2:0]  w_tag;
    logic [2:0]  w_index;
    logic [1:0]  w_offset;
    logic [2:0]  w_miss_idx;
    logic [31:0] w_line;
    logic        w_req;
    logic        w_hit;
    logic        w_start_miss;
    logic        w_write_hit;

    assign w_tag      = bus.ADDRESS[7:5];
    assign w_index    = bus.ADDRESS[4:2];
    assign w_offset   = bus.ADDRESS[1:0];
    assign w_miss_idx = r_miss_blk[2:0];
    assign w_line     = r_data[w_index];

    // READ with WRITE is treated as a write, so WRITE alone selects the store path.
    assign w_req        = bus.READ | bus.WRITE;
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_start_miss = (r_state == IDLE) && w_req && !w_hit;
    assign w_write_hit  = (r_state == IDLE) && bus.WRITE && w_hit;

    // Byte addressed by the current ADDRESS, whether or not it hits.
    assign bus.READDATA = w_line[{w_offset, 3'b000} +: 8];

    // Writeback data always comes from the victim line; it cannot change
    // until UPDATE, so it is stable for the whole WRITEBACK transfer.
    assign bus.MEM_WRITEDATA = r_data[w_miss_idx];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_write_hit) begin
                r_dirty[w_index] <= 1'b1;
            end
            if (r_state == UPDATE) begin
                r_valid[w_miss_idx] <= 1'b1;
                r_dirty[w_miss_idx] <= 1'b0;
            end
        end
    end

    // Data path storage carries no reset: contents are meaningless while the
    // matching valid bit is clear.
    always_ff @(posedge CLK) begin
        if (w_start_miss) begin
            r_miss_blk <= bus.ADDRESS[7:2];
        end
        if ((r_state == FETCH) && !bus.MEM_BUSYWAIT) begin
            r_fill <= bus.MEM_READDATA;
        end
        if (w_write_hit) begin
            r_data[w_index][{w_offset, 3'b000} +: 8] <= bus.WRITEDATA;
        end
        if (r_state == UPDATE) begin
            r_data[w_miss_idx] <= r_fill;
            r_tag[w_miss_idx]  <= r_miss_blk[5:3];
        end
    end

    always_comb begin
        w_next_state    = r_state;
        bus.BUSYWAIT    = 1'b0;
        bus.MEM_READ    = 1'b0;
        bus.MEM_WRITE   = 1'b0;
        bus.MEM_ADDRESS = r_miss_blk;

        case (r_state)
            IDLE: begin
                if (w_start_miss) begin
                    bus.BUSYWAIT = 1'b1;
                    if (r_valid[w_index] && r_dirty[w_index]) begin
                        w_next_state = WRITEBACK;
                    end else begin
                        w_next_state = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                bus.BUSYWAIT    = 1'b1;
                bus.MEM_WRITE   = 1'b1;
                bus.MEM_ADDRESS = {r_tag[w_miss_idx], w_miss_idx};
                if (!bus.MEM_BUSYWAIT) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                bus.BUSYWAIT = 1'b1;
                bus.MEM_READ = 1'b1;
                if (!bus.MEM_BUSYWAIT) begin
                    w_next_state = UPDATE;
                end
            end
            UPDATE: begin
                bus.BUSYWAIT = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    dcache_ctrl_if bus ();

    dcache_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_overlap = 0;
    int          n_unstable = 0;
    logic [5:0]  last_rd_addr = '0;
    logic [5:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    // Main memory: each request is busy for 3 posedges, completes on the 4th.
    initial begin
        int          cnt;
        logic [5:0]  a0;
        logic [31:0] d0;
        cnt = 0;
        a0 = '0;
        d0 = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h09] = 32'hDDCCBBAA;
        mem[6'h11] = 32'h44332211;
        mem[6'h01] = 32'h87654321;
        mem[6'h21] = 32'hA1B2C3D4;
        mem[6'h04] = 32'h0F0E0D0C;
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = 32'h0;
        forever begin
            @(negedge CLK);
            if (bus.MEM_READ && bus.MEM_WRITE) n_overlap++;
            if (bus.MEM_READ || bus.MEM_WRITE) begin
                if (cnt == 4) cnt = 0;
                cnt++;
                if (cnt == 1) begin
                    a0 = bus.MEM_ADDRESS;
                    d0 = bus.MEM_WRITEDATA;
                end else if ((bus.MEM_ADDRESS !== a0) ||
                             (bus.MEM_WRITE && (bus.MEM_WRITEDATA !== d0))) begin
                    n_unstable++;
                end
                if (cnt < 4) begin
                    bus.MEM_BUSYWAIT = 1'b1;
                end else begin
                    bus.MEM_BUSYWAIT = 1'b0;
                    if (bus.MEM_WRITE) begin
                        mem[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
                        last_wr_addr = bus.MEM_ADDRESS;
                        last_wr_data = bus.MEM_WRITEDATA;
                        n_wr++;
                    end else begin
                        bus.MEM_READDATA = mem[bus.MEM_ADDRESS];
                        last_rd_addr = bus.MEM_ADDRESS;
                        n_rd++;
                    end
                end
            end else begin
                cnt = 0;
                bus.MEM_BUSYWAIT = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // Drive one CPU access at a negedge and hold it until BUSYWAIT drops.
    task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wdata, output logic busy0,
                              output int stall, output logic [7:0] rdata);
        bus.READ = rd;
        bus.WRITE = wr;
        bus.ADDRESS = addr;
        bus.WRITEDATA = wdata;
        #1;
        busy0 = bus.BUSYWAIT;
        stall = 0;
        while ((bus.BUSYWAIT !== 1'b0) && (stall < 100)) begin
            @(negedge CLK);
            #1;
            stall++;
        end
        rdata = bus.READDATA;
        @(negedge CLK);
        bus.READ = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        bus.READ = 1'b0;
        bus.WRITE = 1'b0;
        bus.ADDRESS = 8'h00;
        bus.WRITEDATA = 8'h00;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        #1;
        n_cmp++; if (bus.BUSYWAIT !== 1'b0) begin n_err++; $display("FAIL reset_busywait: got %b want 0", bus.BUSYWAIT); end
        n_cmp++; if (bus.MEM_READ !== 1'b0) begin n_err++; $display("FAIL reset_mem_read: got %b want 0", bus.MEM_READ); end
        n_cmp++; if (bus.MEM_WRITE !== 1'b0) begin n_err++; $display("FAIL reset_mem_write: got %b want 0", bus.MEM_WRITE); end
        @(negedge CLK);
    endtask

    task automatic test_cold_read();
        logic b0; int st; logic [7:0] rd; int rd0, wr0;
        rd0 = n_rd; wr0 = n_wr;
        cpu_access(1'b1, 1'b0, 8'h25, 8'h00, b0, st, rd);
        n_cmp++; if (b0 !== 1'b1) begin n_err++; $display("FAIL cold_busy_same_cycle: got %b want 1", b0); end
        n_cmp++; if (st != 6) begin n_err++; $display("FAIL cold_stall: got %0d want 6", st); end
        n_cmp++; if (rd !== 8'hBB) begin n_err++; $display("FAIL cold_rdata: got %h want bb", rd); end
        n_cmp++; if (n_rd - rd0 != 1) begin n_err++; $display("FAIL cold_fetch_count: got %0d want 1", n_rd - rd0); end
        n_cmp++; if (last_rd_addr !== 6'h09) begin n_err++; $display("FAIL cold_fetch_addr: got %h want 09", last_rd_addr); end
        n_cmp++; if (n_wr != wr0) begin n_err++; $display("FAIL cold_no_writeback: got %0d want 0", n_wr - wr0); end
    endtask

    task automatic test_write_hit();
        logic b0; int st; logic [7:0] rd; int rd0, wr0;
        rd0 = n_rd; wr0 = n_wr;
        cpu_access(1'b0, 1'b1, 8'h27, 8'h5A, b0, st, rd);
        n_cmp++; if (b0 !== 1'b0) begin n_err++; $display("FAIL whit_busywait: got %b want 0", b0); end
        cpu_access(1'b1, 1'b0, 8'h27, 8'h00, b0, st, rd);
        n_cmp++; if (st != 0) begin n_err++; $display("FAIL whit_read_stall: got %0d want 0", st); end
        n_cmp++; if (rd !== 8'h5A) begin n_err++; $display("FAIL whit_read_data: got %h want 5a", rd); end
        n_cmp++; if ((n_rd != rd0) || (n_wr != wr0)) begin n_err++; $display("FAIL whit_no_mem: got %0d accesses want 0", (n_rd - rd0) + (n_wr - wr0)); end
    endtask

    task automatic test_dirty_evict();
        logic b0; int st; logic [7:0] rd; int rd0, wr0;
        rd0 = n_rd; wr0 = n_wr;
        cpu_access(1'b1, 1'b0, 8'h45, 8'h00, b0, st, rd);
        n_cmp++; if (st != 10) begin n_err++; $display("FAIL dirty_stall: got %0d want 10", st); end
        n_cmp++; if (n_wr - wr0 != 1) begin n_err++; $display("FAIL dirty_wb_count: got %0d want 1", n_wr - wr0); end
        n_cmp++; if (last_wr_addr !== 6'h09) begin n_err++; $display("FAIL dirty_wb_addr: got %h want 09", last_wr_addr); end
        n_cmp++; if (last_wr_data !== 32'h5ACCBBAA) begin n_err++; $display("FAIL dirty_wb_data: got %h want 5accbbaa", last_wr_data); end
        n_cmp++; if ((n_rd - rd0 != 1) || (last_rd_addr !== 6'h11)) begin n_err++; $display("FAIL dirty_fetch: got count %0d addr %h want 1 11", n_rd - rd0, last_rd_addr); end
        n_cmp++; if (rd !== 8'h22) begin n_err++; $display("FAIL dirty_rdata: got %h want 22", rd); end
        n_cmp++; if (n_overlap != 0) begin n_err++; $display("FAIL dirty_overlap: got %0d want 0", n_overlap); end
        n_cmp++; if (n_unstable != 0) begin n_err++; $display("FAIL dirty_stable: got %0d want 0", n_unstable); end
    endtask

    task automatic test_clean_evict();
        logic b0; int st; logic [7:0] rd; int rd0, wr0;
        rd0 = n_rd; wr0 = n_wr;
        cpu_access(1'b1, 1'b0, 8'h05, 8'h00, b0, st, rd);
        n_cmp++; if ((st != 6) || (rd !== 8'h43)) begin n_err++; $display("FAIL clean1: got stall %0d data %h want 6 43", st, rd); end
        n_cmp++; if (last_rd_addr !== 6'h01) begin n_err++; $display("FAIL clean1_addr: got %h want 01", last_rd_addr); end
        cpu_access(1'b1, 1'b0, 8'h85, 8'h00, b0, st, rd);
        n_cmp++; if ((st != 6) || (rd !== 8'hC3)) begin n_err++; $display("FAIL clean2: got stall %0d data %h want 6 c3", st, rd); end
        n_cmp++; if (last_rd_addr !== 6'h21) begin n_err++; $display("FAIL clean2_addr: got %h want 21", last_rd_addr); end
        n_cmp++; if ((n_wr != wr0) || (n_rd - rd0 != 2)) begin n_err++; $display("FAIL clean_counts: got wr %0d rd %0d want 0 2", n_wr - wr0, n_rd - rd0); end
    endtask

    task automatic test_reset_mid_fetch();
        logic b0; int st; logic [7:0] rd; int k; int rd0;
        bus.READ = 1'b1;
        bus.WRITE = 1'b0;
        bus.ADDRESS = 8'h25;
        #1;
        k = 0;
        while ((bus.MEM_READ !== 1'b1) && (k < 20)) begin
            @(negedge CLK);
            #1;
            k++;
        end
        n_cmp++; if (bus.MEM_READ !== 1'b1) begin n_err++; $display("FAIL rst_fetch_started: got %b want 1", bus.MEM_READ); end
        rd0 = n_rd;
        RESET = 1'b0;
        bus.READ = 1'b0;
        @(negedge CLK);
        #1;
        n_cmp++; if (bus.MEM_READ !== 1'b0) begin n_err++; $display("FAIL rst_mem_read: got %b want 0", bus.MEM_READ); end
        n_cmp++; if (bus.MEM_WRITE !== 1'b0) begin n_err++; $display("FAIL rst_mem_write: got %b want 0", bus.MEM_WRITE); end
        n_cmp++; if (bus.BUSYWAIT !== 1'b0) begin n_err++; $display("FAIL rst_busywait: got %b want 0", bus.BUSYWAIT); end
        n_cmp++; if (n_rd != rd0) begin n_err++; $display("FAIL rst_abandon: got %0d fetches want 0", n_rd - rd0); end
        RESET = 1'b1;
        @(negedge CLK);
        cpu_access(1'b1, 1'b0, 8'h85, 8'h00, b0, st, rd);
        n_cmp++; if (b0 !== 1'b1) begin n_err++; $display("FAIL rst_reread_miss: got %b want 1", b0); end
        n_cmp++; if ((st != 6) || (rd !== 8'hC3)) begin n_err++; $display("FAIL rst_reread: got stall %0d data %h want 6 c3", st, rd); end
    endtask

    task automatic test_read_write_both();
        logic b0; int st; logic [7:0] rd; int wr0;
        cpu_access(1'b1, 1'b1, 8'h10, 8'h3C, b0, st, rd);
        n_cmp++; if ((b0 !== 1'b1) || (st != 6)) begin n_err++; $display("FAIL both_miss: got busy %b stall %0d want 1 6", b0, st); end
        cpu_access(1'b1, 1'b0, 8'h10, 8'h00, b0, st, rd);
        n_cmp++; if ((st != 0) || (rd !== 8'h3C)) begin n_err++; $display("FAIL both_byte0: got stall %0d data %h want 0 3c", st, rd); end
        cpu_access(1'b1, 1'b0, 8'h11, 8'h00, b0, st, rd);
        n_cmp++; if (rd !== 8'h0D) begin n_err++; $display("FAIL both_byte1: got %h want 0d", rd); end
        wr0 = n_wr;
        cpu_access(1'b1, 1'b0, 8'h30, 8'h00, b0, st, rd);
        n_cmp++; if ((st != 10) || (n_wr - wr0 != 1)) begin n_err++; $display("FAIL both_dirty: got stall %0d wb %0d want 10 1", st, n_wr - wr0); end
        n_cmp++; if ((last_wr_addr !== 6'h04) || (last_wr_data !== 32'h0F0E0D3C)) begin n_err++; $display("FAIL both_wb: got %h %h want 04 0f0e0d3c", last_wr_addr, last_wr_data); end
        n_cmp++; if ((n_overlap != 0) || (n_unstable != 0)) begin n_err++; $display("FAIL both_protocol: got overlap %0d unstable %0d want 0 0", n_overlap, n_unstable); end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_evict();
        test_clean_evict();
        test_reset_mid_fetch();
        test_read_write_both();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
